// File: rtl/keycode_event_ctrl.sv
// Turns the PIO key code into press/release/(optional) repeat events queued in a 2-entry FWFT FIFO.
// Define KEYCODE_AUTOREPEAT_EN to build the DELAY/REPEAT FSM and repeat counter.
module keycode_event_ctrl #(
  parameter int DELAY_CYC = 25000000,
  parameter int RATE_CYC  = 5000000,
  parameter int CNT_W     = 25
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] key_code_in,
  input  logic       en,
  output logic       evt_valid,
  input  logic       evt_ready,
  output logic [7:0] evt_code,
  output logic [1:0] evt_type,
  output logic       ovf,
  input  logic       ovf_clr,
  output logic [1:0] o_dbg_state
);

  // evt_valid/evt_ready: the head event transfers on every cycle where both are high;
  // evt_valid never depends on evt_ready and the head stays stable until it is accepted.

  localparam logic [1:0] TYPE_PRESS   = 2'b01;
  localparam logic [1:0] TYPE_RELEASE = 2'b10;
  localparam logic [1:0] TYPE_REPEAT  = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [7:0] r_prev_code;
  logic [9:0] r_q0;
  logic [9:0] r_q1;
  logic [1:0] r_cnt;
  logic       r_ovf;

  logic       w_change;
  logic       w_gen;
  logic       w_pop;
  logic [1:0] w_cnt_ap;
  logic       w_rpt_req;
  logic       w_rpt_push;
  logic       w_ev0_v;
  logic       w_ev1_v;
  logic [9:0] w_ev0;
  logic [9:0] w_ev1;
  logic       w_a_v;
  logic [9:0] w_a;
  logic       w_b_v;
  logic       w_drop;
  logic [9:0] w_s0;
  logic [9:0] w_s1;
  logic [1:0] w_n;

  assign w_change  = (key_code_in != r_prev_code);
  assign w_gen     = en && w_change;
  assign evt_valid = (r_cnt != 2'd0);
  assign w_pop     = evt_valid && evt_ready;
  assign w_cnt_ap  = r_cnt - {1'b0, w_pop};

  assign evt_code  = evt_valid ? r_q0[7:0] : 8'h00;
  assign evt_type  = evt_valid ? r_q0[9:8] : 2'b00;
  assign ovf       = r_ovf;

  // A->B yields release(A) in the first slot and press(B) in the second.
  always_comb begin
    w_ev0_v = 1'b0;
    w_ev1_v = 1'b0;
    w_ev0   = 10'h000;
    w_ev1   = 10'h000;
    if (w_gen) begin
      if (r_prev_code == 8'h00) begin
        w_ev0_v = 1'b1;
        w_ev0   = {TYPE_PRESS, key_code_in};
      end else if (key_code_in == 8'h00) begin
        w_ev0_v = 1'b1;
        w_ev0   = {TYPE_RELEASE, r_prev_code};
      end else begin
        w_ev0_v = 1'b1;
        w_ev0   = {TYPE_RELEASE, r_prev_code};
        w_ev1_v = 1'b1;
        w_ev1   = {TYPE_PRESS, key_code_in};
      end
    end
  end

  // Repeats only go into an otherwise empty FIFO and never count as drops.
  assign w_rpt_push = w_rpt_req && (w_cnt_ap == 2'd0);
  assign w_a_v      = (w_ev0_v && (w_cnt_ap != 2'd2)) || w_rpt_push;
  assign w_a        = w_ev0_v ? w_ev0 : {TYPE_REPEAT, r_prev_code};
  assign w_b_v      = w_ev1_v && (w_cnt_ap == 2'd0);
  assign w_drop     = (w_ev0_v && (w_cnt_ap == 2'd2)) || (w_ev1_v && (w_cnt_ap != 2'd0));

  always_comb begin
    w_s0 = w_pop ? r_q1 : r_q0;
    w_s1 = w_pop ? 10'h000 : r_q1;
    w_n  = w_cnt_ap;
    if (w_a_v) begin
      if (w_n == 2'd0) begin
        w_s0 = w_a;
      end else begin
        w_s1 = w_a;
      end
      w_n = w_n + 2'd1;
    end
    if (w_b_v) begin
      w_s1 = w_ev1;
      w_n  = w_n + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_code <= 8'h00;
      r_q0        <= 10'h000;
      r_q1        <= 10'h000;
      r_cnt       <= 2'd0;
      r_ovf       <= 1'b0;
    end else begin
      r_prev_code <= key_code_in;
      r_q0        <= w_s0;
      r_q1        <= w_s1;
      r_cnt       <= w_n;
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef KEYCODE_AUTOREPEAT_EN
  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_rcnt;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] w_rcnt_nxt;

  assign o_dbg_state = r_state;

  // Key changes take priority over timer expiry; en low forces IDLE with no pushes.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rpt_req   = 1'b0;
    if (!en) begin
      w_state_nxt = ST_IDLE;
      w_rcnt_nxt  = '0;
    end else if (w_change) begin
      if (key_code_in == 8'h00) begin
        w_state_nxt = ST_IDLE;
        w_rcnt_nxt  = '0;
      end else begin
        w_state_nxt = ST_DELAY;
        w_rcnt_nxt  = CNT_W'(DELAY_CYC - 1);
      end
    end else if ((r_state == ST_DELAY) || (r_state == ST_REPEAT)) begin
      if (r_rcnt == '0) begin
        w_state_nxt = ST_REPEAT;
        w_rcnt_nxt  = CNT_W'(RATE_CYC - 1);
        w_rpt_req   = 1'b1;
      end else begin
        w_rcnt_nxt = r_rcnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_rcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rcnt  <= w_rcnt_nxt;
    end
  end
`else
  logic w_unused_cfg;

  assign w_rpt_req    = 1'b0;
  assign o_dbg_state  = ST_IDLE;
  assign w_unused_cfg = ((DELAY_CYC + RATE_CYC + CNT_W) == 0) ||
                        (ST_DELAY == ST_REPEAT) || (TYPE_REPEAT == TYPE_PRESS);
`endif

endmodule
